acc_alu: RTL and testbench

ACC_ALU -- requirements
Module: acc_alu

---
 rtl/acc_alu_pkg.sv | 27 ++
 rtl/acc_alu_sat_arith.sv | 38 +++
 rtl/acc_alu.sv | 72 +++++++
 tb/tb_acc_alu.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/acc_alu_pkg.sv
// Shared opcode encodings and flag bit positions for the accumulator node.
package acc_alu_pkg;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_MOV = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_NEG = 3'd4;
    localparam logic [2:0] OP_SAV = 3'd5;
    localparam logic [2:0] OP_SWP = 3'd6;
    localparam logic [2:0] OP_CLR = 3'd7;

    // res_flags = {neg, zero, pos}
    localparam int FLAG_NEG  = 2;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_POS  = 0;

    function automatic logic [2:0] make_flags(input logic neg, input logic zero);
        logic [2:0] f;
        f            = '0;
        f[FLAG_NEG]  = neg;
        f[FLAG_ZERO] = zero;
        f[FLAG_POS]  = !neg && !zero;
        return f;
    endfunction

endpackage

// File: rtl/acc_alu_sat_arith.sv
// Saturating MOV/ADD/SUB/NEG evaluated one bit wider than the datapath, then clamped.
module sat_arith
    import acc_alu_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int LIMIT = 999
) (
    input  logic              [2:0]       op,
    input  logic signed       [WIDTH-1:0] acc,
    input  logic signed       [WIDTH-1:0] src,
    output logic signed       [WIDTH-1:0] result
);

    localparam logic signed [WIDTH:0] HI = (WIDTH+1)'(LIMIT);
    localparam logic signed [WIDTH:0] LO = -HI;

    logic signed [WIDTH:0] acc_x;
    logic signed [WIDTH:0] src_x;
    logic signed [WIDTH:0] raw;

    assign acc_x = {acc[WIDTH-1], acc};
    assign src_x = {src[WIDTH-1], src};

    always_comb begin
        raw = acc_x;
        case (op)
            OP_MOV:  raw = src_x;
            OP_ADD:  raw = acc_x + src_x;
            OP_SUB:  raw = acc_x - src_x;
            OP_NEG:  raw = -acc_x;
            default: raw = acc_x;
        endcase
        if (raw > HI)      result = HI[WIDTH-1:0];
        else if (raw < LO) result = LO[WIDTH-1:0];
        else               result = raw[WIDTH-1:0];
    end

endmodule

// File: rtl/acc_alu.sv
// Accumulator/backup register pair with a single-entry result register and
// valid/ready handshakes on both sides.
module acc_alu
    import acc_alu_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int LIMIT = 999
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              op,
    input  logic signed [WIDTH-1:0] src,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [WIDTH-1:0] res_acc,
    output logic [2:0]              res_flags,
    output logic signed [WIDTH-1:0] acc_q,
    output logic signed [WIDTH-1:0] bak_q
);

    logic                    accept;
    logic signed [WIDTH-1:0] arith;
    logic signed [WIDTH-1:0] acc_nxt;
    logic signed [WIDTH-1:0] bak_nxt;

    assign in_ready = !res_valid || res_ready;
    assign accept   = in_valid && in_ready;

    sat_arith #(.WIDTH(WIDTH), .LIMIT(LIMIT)) u_sat (
        .op     (op),
        .acc    (acc_q),
        .src    (src),
        .result (arith)
    );

    always_comb begin
        acc_nxt = acc_q;
        bak_nxt = bak_q;
        case (op)
            OP_MOV, OP_ADD, OP_SUB, OP_NEG: acc_nxt = arith;
            OP_SAV: bak_nxt = acc_q;
            OP_SWP: begin
                acc_nxt = bak_q;
                bak_nxt = acc_q;
            end
            OP_CLR: acc_nxt = '0;
            default: ;
        endcase
    end

    // Result is registered from acc_nxt, so res_ready never reaches res_acc combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            bak_q     <= '0;
            res_valid <= 1'b0;
            res_acc   <= '0;
            res_flags <= make_flags(1'b0, 1'b1);
        end else if (accept) begin
            acc_q     <= acc_nxt;
            bak_q     <= bak_nxt;
            res_valid <= 1'b1;
            res_acc   <= acc_nxt;
            res_flags <= make_flags(acc_nxt[WIDTH-1], acc_nxt == '0);
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acc_alu.sv
// Directed plus randomized checks of acc_alu against an integer reference model.
module tb_acc_alu;

    localparam int WIDTH = 11;
    localparam int LIMIT = 999;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              op;
    logic signed [WIDTH-1:0] src;
    logic                    res_valid;
    logic                    res_ready;
    logic signed [WIDTH-1:0] res_acc;
    logic [2:0]              res_flags;
    logic signed [WIDTH-1:0] acc_q;
    logic signed [WIDTH-1:0] bak_q;

    int vectors    = 0;
    int miscompares = 0;

    // reference model state
    int m_acc, m_bak, m_res;
    bit m_valid;

    always #5 clk = ~clk;

    acc_alu #(.WIDTH(WIDTH), .LIMIT(LIMIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src       (src),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_acc   (res_acc),
        .res_flags (res_flags),
        .acc_q     (acc_q),
        .bak_q     (bak_q)
    );

    function automatic int sat(input int x);
        if (x > LIMIT)  return LIMIT;
        if (x < -LIMIT) return -LIMIT;
        return x;
    endfunction

    function automatic logic [2:0] flags_for(input int v);
        if (v < 0)  return 3'b100;
        if (v == 0) return 3'b010;
        return 3'b001;
    endfunction

    task automatic model_apply(input logic [2:0] o, input int s);
        int t;
        case (o)
            3'd1: m_acc = sat(s);
            3'd2: m_acc = sat(m_acc + s);
            3'd3: m_acc = sat(m_acc - s);
            3'd4: m_acc = sat(-m_acc);
            3'd5: m_bak = m_acc;
            3'd6: begin t = m_acc; m_acc = m_bak; m_bak = t; end
            3'd7: m_acc = 0;
            default: ;
        endcase
        m_res   = m_acc;
        m_valid = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] w(input int v);
        logic [WIDTH-1:0] t;
        t = v[WIDTH-1:0];
        return {{(32-WIDTH){1'b0}}, t};
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, ".res_valid"}, {31'b0, res_valid}, {31'b0, m_valid});
        chk({tag, ".res_acc"},   w(int'(res_acc)),  w(m_res));
        chk({tag, ".res_flags"}, {29'b0, res_flags}, {29'b0, flags_for(m_res)});
        chk({tag, ".acc_q"},     w(int'(acc_q)),    w(m_acc));
        chk({tag, ".bak_q"},     w(int'(bak_q)),    w(m_bak));
    endtask

    // one accepted op with res_ready=1; leaves in_valid asserted for back-to-back use
    task automatic step_op(input string tag, input logic [2:0] o, input int s);
        in_valid  = 1'b1;
        op        = o;
        src       = s[WIDTH-1:0];
        res_ready = 1'b1;
        #1;
        chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        model_apply(o, int'($signed(s[WIDTH-1:0])));
        chk_state(tag);
    endtask

    task automatic idle_cycle(input string tag);
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        m_valid = 1'b0;
        chk_state(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] r;
        logic [2:0] ro;
        bit acc_ok;

        rst = 1'b1; in_valid = 1'b0; op = '0; src = '0; res_ready = 1'b0;
        m_acc = 0; m_bak = 0; m_res = 0; m_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset");
        rst = 1'b0;
        #1;
        chk("reset.in_ready", {31'b0, in_ready}, 32'd1);

        // saturating add
        step_op("mov500", 3'd1, 500);
        step_op("add600", 3'd2, 600);
        chk("add600.acc_abs", w(int'(acc_q)), w(999));
        // negative side
        step_op("mov-800", 3'd1, -800);
        step_op("sub400",  3'd3, 400);
        step_op("neg",     3'd4, 0);
        chk("neg.res_abs", w(int'(res_acc)), w(999));
        // save / swap
        step_op("mov7", 3'd1, 7);
        step_op("sav",  3'd5, 0);
        step_op("mov3", 3'd1, 3);
        step_op("swp",  3'd6, 0);
        chk("swp.res_abs", w(int'(res_acc)), w(7));
        chk("swp.bak_abs", w(int'(bak_q)), w(3));
        // out-of-range src clamps, CLR, NOP
        step_op("mov1023", 3'd1, 1023);
        step_op("mov-1024", 3'd1, -1024);
        step_op("neg_min", 3'd4, 0);
        step_op("clr", 3'd7, 0);
        step_op("nop", 3'd0, 123);
        idle_cycle("idle0");

        // back-to-back ADD 1 x10 from zero, no bubbles
        step_op("b2b_clr", 3'd7, 0);
        for (int i = 1; i <= 10; i++) begin
            step_op("b2b_add", 3'd2, 1);
            chk("b2b.count", w(int'(res_acc)), w(i));
        end

        // backpressure: stall 3 cycles with in_valid held
        step_op("bp_add", 3'd2, 1);
        res_ready = 1'b0; in_valid = 1'b1; op = 3'd2; src = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp.in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
            chk_state("bp.hold");
        end
        res_ready = 1'b1;
        #1;
        chk("bp.release_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        model_apply(3'd2, 1);
        chk_state("bp.release");

        // reset with a pending result and an op presented
        in_valid = 1'b1; op = 3'd1; src = 5; res_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        m_acc = 0; m_bak = 0; m_res = 0; m_valid = 1'b0;
        chk_state("rst_mid");
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid.in_ready", {31'b0, in_ready}, 32'd1);
        chk_state("rst_mid.after");

        // randomized traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            r  = WIDTH'($urandom);
            ro = 3'($urandom);
            in_valid  = ($urandom % 3) != 0;
            res_ready = ($urandom % 4) != 0;
            op  = ro;
            src = r;
            #1;
            chk("rnd.in_ready", {31'b0, in_ready}, {31'b0, (!m_valid || res_ready)});
            acc_ok = in_valid && (!m_valid || res_ready);
            @(posedge clk); #1;
            if (acc_ok) model_apply(ro, int'($signed(r)));
            else if (res_ready) m_valid = 1'b0;
            chk_state("rnd");
        end

        in_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
